answer_input: RTL and testbench
===============================

# answer_input

Front-end stage for the trivia game. It turns the raw answer switches and the raw "go" key into one clean, single-cycle answer submission per press. It also runs a per-question countdown that auto-submits a blank answer on expiry. Its `submit`, `ans` and `ans_valid` outputs feed the question-sequencing FSM and the score and win-streak logic directly.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before the go level is accepted.
- `CYCLES_PER_SECOND`, default 50000000: prescaler period for the countdown tick.
- `TIMEOUT_SECONDS`, default 10 (range 1–15): countdown start value per question.
- `clock`  in  1: system clock.
- `resetn`  in  1: reset, synchronous, active-low. Clock is `clock`.
- `ans_raw`  in  4: raw answer switches, asynchronous.
- `go_raw_n`  in  1: raw go key, asynchronous, low = pressed.
- `enable`  in  1: game in progress; low holds the block idle.
- `submit`  out  1: one-cycle pulse per accepted answer or timeout.
- `ans`  out  4: captured answer; held until the next `submit`.
- `ans_valid`  out  1: captured answer has exactly one bit set; held with `ans`.
- `timed_out`  out  1: last submission came from timeout; held with `ans`.
- `seconds_left`  out  4: remaining seconds, for HEX display.

## Operation
- **Synchronisers.** `ans_raw` and `go_raw_n` each pass through a 2-FF synchroniser.
- **Debounce (go only).**
  - A counter increments while the synchronised sample differs from the debounced level, and clears when they are equal.
  - On reaching `DEBOUNCE_CYCLES`, the debounced level takes the sample and the counter clears.
  - The debounced level resets to 1 (released).
- **Press.** A press is a debounced 1→0 transition, giving a one-cycle internal strobe.
- **FSM states:** IDLE, ARMED, WAIT_RELEASE. Reset state is IDLE.
- **IDLE**
  - `seconds_left` = `TIMEOUT_SECONDS`, prescaler = 0.
  - `enable`=1 → ARMED.
- **ARMED**
  - Prescaler counts 0..`CYCLES_PER_SECOND`-1. On wrap it emits a tick and `seconds_left` decrements.
  - On a press: `submit`=1, `ans` = synchronised switches, `ans_valid` = popcount==1, `timed_out`=0 → WAIT_RELEASE.
  - On a tick with `seconds_left`==1: `seconds_left`→0, `submit`=1, `ans`=4'b0000, `ans_valid`=0, `timed_out`=1 → WAIT_RELEASE.
  - Press and timeout tick in the same cycle: the press wins, `timed_out`=0.
  - `enable`=0 → IDLE, with no submit and no output change.
- **WAIT_RELEASE**
  - Waits for a debounced level of 1.
  - Then: `enable`=1 → ARMED with `seconds_left` = `TIMEOUT_SECONDS` and prescaler 0; `enable`=0 → IDLE.
  - Presses are impossible here, and no submit occurs.
- **Widths.** `seconds_left` is 4 bits and never wraps below 0. The prescaler is sized by `$clog2(CYCLES_PER_SECOND)`.
- **Reset values.** `submit`=0, `ans`=0, `ans_valid`=0, `timed_out`=0, `seconds_left`=`TIMEOUT_SECONDS`, FSM=IDLE, debounced level=1. Reset mid-operation aborts any pending submission.

## Timing
- All outputs are registered. `submit` is high for exactly one cycle, and `ans`/`ans_valid`/`timed_out` update in that same cycle.
- **Press latency.** With `go_raw_n` first sampled low at edge t and held low, `submit` is high in the cycle after edge t+`DEBOUNCE_CYCLES`+2.
- **Timeout latency.** `submit` fires exactly `TIMEOUT_SECONDS`×`CYCLES_PER_SECOND` cycles after entering ARMED.
- **Answer timing.** `ans_raw` must be stable for 2 cycles before the press strobe; the value captured is the synchronised one.
- **Rate limit.** At most one submit per press-release cycle. A held key never re-submits, even across timeouts.
- **Downstream contract.** Consumers act only on `submit`. `ans` is stable at all other times.

## Structure
- Shared package `trivia_pkg`:
  - FSM state encoding.
  - `ANS_NONE` = 4'b0000.
  - `ANS_W` = 4.
  - `SECONDS_W` = 4.
- Sub-module `debounce`: synchroniser plus debounce counter, parameterised by `DEBOUNCE_CYCLES`. Output is the debounced level.
- Top level: answer synchroniser, edge detect, prescaler, countdown and FSM.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `CYCLES_PER_SECOND`=8, `TIMEOUT_SECONDS`=3.
- **Reset.** Hold `resetn`=0 for 3 cycles → all outputs 0, `seconds_left`=3, no `submit` for 10 cycles with `enable`=0.
- **Clean press.** `enable`=1, `ans_raw`=4'b0100, `go_raw_n` low from edge t and held 30 cycles → exactly one `submit`, after edge t+6, with `ans`=0100, `ans_valid`=1, `timed_out`=0. On release, `seconds_left` reloads to 3.
- **Bounce and invalid answer.**
  - `go_raw_n` toggling 3 low / 1 high for 40 cycles → no `submit`.
  - Then `ans_raw`=4'b0110 with a clean press → `ans`=0110, `ans_valid`=0.
- **Timeout.** `enable`=1 with no press → `seconds_left` goes 3, 2, 1, 0, then `submit` at cycle 24 with `ans`=0000, `ans_valid`=0, `timed_out`=1. Next cycles: `seconds_left`=3, ARMED.
- **Simultaneous press and timeout.** Press strobe aligned with the final tick → `timed_out`=0 and `ans` = switches.
- **Abort paths.**
  - `enable`→0 at `seconds_left`=2 → no `submit`, `seconds_left`=3.
  - `resetn`=0 during WAIT_RELEASE → IDLE; prior `ans` cleared to 0.

Source files
------------

// File: rtl/trivia_pkg.sv
// Shared types and constants for the trivia game front end.
package trivia_pkg;

  localparam int ANS_W     = 4;
  localparam int SECONDS_W = 4;

  localparam logic [ANS_W-1:0] ANS_NONE = 4'b0000;

  // Answer-input FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_ARMED        = 2'd1,
    ST_WAIT_RELEASE = 2'd2
  } state_t;

  // A legal answer has exactly one switch up.
  function automatic logic is_one_hot(input logic [ANS_W-1:0] a);
    return ($countones(a) == 1);
  endfunction

endpackage

// File: rtl/answer_input_if.sv
// Answer submission bus from the answer-input stage to the game logic.
//
// Handshake: submit is a single-cycle valid strobe with no ready/back-pressure.
// Consumers must take ans/ans_valid/timed_out in the cycle submit is high;
// those fields are updated only in that cycle and held stable otherwise.
interface answer_input_if;
  import trivia_pkg::*;

  logic                 submit;
  logic [ANS_W-1:0]     ans;
  logic                 ans_valid;
  logic                 timed_out;
  logic [SECONDS_W-1:0] seconds_left;
  state_t               state;

  modport master (
    output submit, ans, ans_valid, timed_out, seconds_left, state
  );

  modport slave (
    input submit, ans, ans_valid, timed_out, seconds_left, state
  );

endinterface

// File: rtl/debounce.sv
// Two-flop synchroniser followed by a stability counter for the go key.
// The output level only follows the input after it has differed from the
// current level for DEBOUNCE_CYCLES consecutive cycles.
module debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Synchronise the asynchronous key; idles released (high).
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing samples; commit the new level on the last one.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt   <= '0;
      level <= 1'b1;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/answer_input.sv
// Trivia answer front end: synchronises the answer switches, turns a debounced
// go press into one submission, and auto-submits a blank answer when the
// per-question countdown expires.
module answer_input
  import trivia_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int CYCLES_PER_SECOND = 50000000,
  parameter int TIMEOUT_SECONDS   = 10
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [ANS_W-1:0] ans_raw,
  input  logic             go_raw_n,
  input  logic             enable,
  answer_input_if.master   bus
);

  localparam int PRE_W = (CYCLES_PER_SECOND > 1) ? $clog2(CYCLES_PER_SECOND) : 1;
  localparam logic [PRE_W-1:0]     PRE_MAX  = PRE_W'(CYCLES_PER_SECOND - 1);
  localparam logic [SECONDS_W-1:0] SEC_INIT = SECONDS_W'(TIMEOUT_SECONDS);
  localparam logic [SECONDS_W-1:0] SEC_ONE  = SECONDS_W'(1);

  state_t state, state_n;

  logic [ANS_W-1:0]     ans_s1, ans_s2;
  logic                 go_level, go_level_q;
  logic                 press;
  logic                 tick;

  logic [PRE_W-1:0]     prescaler, prescaler_n;
  logic [SECONDS_W-1:0] seconds, seconds_n;
  logic                 submit_r, submit_n;
  logic [ANS_W-1:0]     ans_r, ans_n;
  logic                 valid_r, valid_n;
  logic                 timed_r, timed_n;

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_go_debounce (
    .clock (clock),
    .resetn(resetn),
    .raw   (go_raw_n),
    .level (go_level)
  );

  // Synchronise the answer switches; the second stage is what gets captured.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ans_s1 <= ANS_NONE;
      ans_s2 <= ANS_NONE;
    end else begin
      ans_s1 <= ans_raw;
      ans_s2 <= ans_s1;
    end
  end

  // Delay the debounced level so a release-to-press edge becomes a strobe.
  always_ff @(posedge clock) begin
    if (!resetn) go_level_q <= 1'b1;
    else         go_level_q <= go_level;
  end

  assign press = go_level_q & ~go_level;
  assign tick  = (state == ST_ARMED) && (prescaler == PRE_MAX);

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_n;
  end

  // Next state, countdown and submission decode.
  always_comb begin
    state_n     = state;
    prescaler_n = prescaler;
    seconds_n   = seconds;
    submit_n    = 1'b0;
    ans_n       = ans_r;
    valid_n     = valid_r;
    timed_n     = timed_r;
    case (state)
      ST_IDLE: begin
        prescaler_n = '0;
        seconds_n   = SEC_INIT;
        if (enable) state_n = ST_ARMED;
      end
      ST_ARMED: begin
        if (!enable) begin
          state_n = ST_IDLE;
        end else begin
          prescaler_n = tick ? '0 : prescaler + PRE_W'(1);
          if (tick && (seconds != '0)) seconds_n = seconds - SEC_ONE;
          // A press outranks a timeout landing in the same cycle.
          if (press) begin
            submit_n = 1'b1;
            ans_n    = ans_s2;
            valid_n  = is_one_hot(ans_s2);
            timed_n  = 1'b0;
            state_n  = ST_WAIT_RELEASE;
          end else if (tick && (seconds == SEC_ONE)) begin
            submit_n = 1'b1;
            ans_n    = ANS_NONE;
            valid_n  = 1'b0;
            timed_n  = 1'b1;
            state_n  = ST_WAIT_RELEASE;
          end
        end
      end
      ST_WAIT_RELEASE: begin
        if (go_level) begin
          if (enable) begin
            state_n     = ST_ARMED;
            seconds_n   = SEC_INIT;
            prescaler_n = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Registered countdown and submission outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      prescaler <= '0;
      seconds   <= SEC_INIT;
      submit_r  <= 1'b0;
      ans_r     <= ANS_NONE;
      valid_r   <= 1'b0;
      timed_r   <= 1'b0;
    end else begin
      prescaler <= prescaler_n;
      seconds   <= seconds_n;
      submit_r  <= submit_n;
      ans_r     <= ans_n;
      valid_r   <= valid_n;
      timed_r   <= timed_n;
    end
  end

  assign bus.submit       = submit_r;
  assign bus.ans          = ans_r;
  assign bus.ans_valid    = valid_r;
  assign bus.timed_out    = timed_r;
  assign bus.seconds_left = seconds;
  assign bus.state        = state;

endmodule

// File: tb/tb_answer_input.sv
// Directed bench for answer_input with a submission scoreboard.
module tb_answer_input;
  import trivia_pkg::*;

  logic       clock;
  logic       resetn;
  logic [3:0] ans_raw;
  logic       go_raw_n;
  logic       enable;

  int checks   = 0;
  int failures = 0;

  logic [5:0] exp_q[$];
  logic [5:0] mon_exp;
  logic [3:0] last_ans;
  logic       prev_submit;

  int n_sub;
  int first_k;

  answer_input_if bus ();

  answer_input #(
    .DEBOUNCE_CYCLES  (4),
    .CYCLES_PER_SECOND(8),
    .TIMEOUT_SECONDS  (3)
  ) dut (
    .clock   (clock),
    .resetn  (resetn),
    .ans_raw (ans_raw),
    .go_raw_n(go_raw_n),
    .enable  (enable),
    .bus     (bus)
  );

  // Clock and reset block.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: every submit pops one expected {ans, ans_valid, timed_out}.
  initial begin
    last_ans    = '0;
    prev_submit = 1'b0;
    forever begin
      @(negedge clock);
      if (resetn) begin
        if (bus.submit) begin
          chk("submit_width", {31'd0, prev_submit}, 32'd0);
          if (exp_q.size() == 0) begin
            chk("unexpected_submit", {31'd0, bus.submit}, 32'd0);
          end else begin
            mon_exp = exp_q.pop_front();
            chk("sb_ans", {28'd0, bus.ans}, {28'd0, mon_exp[5:2]});
            chk("sb_ans_valid", {31'd0, bus.ans_valid}, {31'd0, mon_exp[1]});
            chk("sb_timed_out", {31'd0, bus.timed_out}, {31'd0, mon_exp[0]});
          end
        end else begin
          chk("ans_stable", {28'd0, bus.ans}, {28'd0, last_ans});
        end
      end
      last_ans    = bus.ans;
      prev_submit = bus.submit;
    end
  end

  // Directed stimulus.
  initial begin
    resetn   = 1'b0;
    enable   = 1'b0;
    go_raw_n = 1'b1;
    ans_raw  = 4'b0000;

    // Reset values.
    repeat (3) tick();
    chk("rst_submit", {31'd0, bus.submit}, 32'd0);
    chk("rst_ans", {28'd0, bus.ans}, 32'd0);
    chk("rst_ans_valid", {31'd0, bus.ans_valid}, 32'd0);
    chk("rst_timed_out", {31'd0, bus.timed_out}, 32'd0);
    chk("rst_seconds", {28'd0, bus.seconds_left}, 32'd3);
    chk("rst_state", 32'(bus.state), 32'(ST_IDLE));
    resetn = 1'b1;
    repeat (10) tick();
    chk("idle_seconds", {28'd0, bus.seconds_left}, 32'd3);
    chk("idle_state", 32'(bus.state), 32'(ST_IDLE));

    // Clean press: submit exactly once, seven samples after driving the key.
    ans_raw = 4'b0100;
    enable  = 1'b1;
    repeat (3) tick();
    exp_q.push_back({4'b0100, 1'b1, 1'b0});
    go_raw_n = 1'b0;
    n_sub    = 0;
    first_k  = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (bus.submit) begin
        n_sub++;
        if (first_k == 0) first_k = k;
      end
    end
    chk("press_latency", 32'(first_k), 32'd7);
    chk("press_count", 32'(n_sub), 32'd1);
    chk("press_state", 32'(bus.state), 32'(ST_WAIT_RELEASE));
    go_raw_n = 1'b1;
    repeat (8) tick();
    chk("release_state", 32'(bus.state), 32'(ST_ARMED));
    chk("release_seconds", {28'd0, bus.seconds_left}, 32'd3);

    // Bouncing key never settles long enough to count as a press.
    enable = 1'b0;
    repeat (2) tick();
    n_sub = 0;
    for (int k = 0; k < 40; k++) begin
      go_raw_n = (k % 4 == 3);
      tick();
      if (bus.submit) n_sub++;
    end
    chk("bounce_count", 32'(n_sub), 32'd0);
    go_raw_n = 1'b1;
    repeat (4) tick();

    // Two switches up: captured as-is but flagged invalid.
    enable  = 1'b1;
    ans_raw = 4'b0110;
    repeat (3) tick();
    exp_q.push_back({4'b0110, 1'b0, 1'b0});
    go_raw_n = 1'b0;
    repeat (10) tick();
    chk("invalid_ans", {28'd0, bus.ans}, 32'h6);
    chk("invalid_valid", {31'd0, bus.ans_valid}, 32'd0);
    go_raw_n = 1'b1;
    repeat (8) tick();

    // Timeout: countdown 3,2,1 then blank submit 24 cycles after arming.
    enable = 1'b0;
    repeat (2) tick();
    exp_q.push_back({4'b0000, 1'b0, 1'b1});
    enable = 1'b1;
    for (int k = 0; k <= 24; k++) begin
      tick();
      chk("to_seconds", {28'd0, bus.seconds_left},
          (k == 24) ? 32'd0 : 32'(3 - k / 8));
      chk("to_submit", {31'd0, bus.submit}, (k == 24) ? 32'd1 : 32'd0);
    end
    tick();
    chk("to_rearm_state", 32'(bus.state), 32'(ST_ARMED));
    chk("to_rearm_seconds", {28'd0, bus.seconds_left}, 32'd3);

    // Press strobe lands on the final tick: the press must win.
    ans_raw = 4'b1000;
    repeat (17) tick();
    exp_q.push_back({4'b1000, 1'b1, 1'b0});
    go_raw_n = 1'b0;
    repeat (7) tick();
    chk("tie_submit", {31'd0, bus.submit}, 32'd1);
    chk("tie_timed_out", {31'd0, bus.timed_out}, 32'd0);
    chk("tie_ans", {28'd0, bus.ans}, 32'h8);
    go_raw_n = 1'b1;
    repeat (8) tick();

    // Dropping enable mid-countdown aborts without a submit.
    enable = 1'b0;
    repeat (2) tick();
    enable = 1'b1;
    tick();
    repeat (9) tick();
    chk("abort_pre_seconds", {28'd0, bus.seconds_left}, 32'd2);
    chk("abort_pre_state", 32'(bus.state), 32'(ST_ARMED));
    enable = 1'b0;
    repeat (2) tick();
    chk("abort_state", 32'(bus.state), 32'(ST_IDLE));
    chk("abort_seconds", {28'd0, bus.seconds_left}, 32'd3);

    // Reset while waiting for release clears the captured answer.
    enable  = 1'b1;
    ans_raw = 4'b0001;
    repeat (3) tick();
    exp_q.push_back({4'b0001, 1'b1, 1'b0});
    go_raw_n = 1'b0;
    repeat (10) tick();
    chk("wr_state", 32'(bus.state), 32'(ST_WAIT_RELEASE));
    chk("wr_ans", {28'd0, bus.ans}, 32'h1);
    resetn = 1'b0;
    repeat (2) tick();
    chk("wr_rst_ans", {28'd0, bus.ans}, 32'd0);
    chk("wr_rst_valid", {31'd0, bus.ans_valid}, 32'd0);
    chk("wr_rst_timed_out", {31'd0, bus.timed_out}, 32'd0);
    chk("wr_rst_submit", {31'd0, bus.submit}, 32'd0);
    chk("wr_rst_seconds", {28'd0, bus.seconds_left}, 32'd3);
    chk("wr_rst_state", 32'(bus.state), 32'(ST_IDLE));
    enable   = 1'b0;
    go_raw_n = 1'b1;
    resetn   = 1'b1;
    repeat (10) tick();
    chk("final_state", 32'(bus.state), 32'(ST_IDLE));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
